// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the PLL control slice: sequencer states and default timing.
// Also imported by other blocks that sit next to the PLL wrapper.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_state_t;

    localparam int DEF_RST_PULSE_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 200000;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_MAX_RETRIES         = 3;
    localparam int DEF_CNT_W               = 18;

    localparam int RETRY_CNT_W = 2;
    localparam int LOL_CNT_W   = 8;

endpackage

// File: rtl/sync_2ff.sv
// One-bit two-flop synchronizer for slow status inputs crossing into the local clock.
// Both flops clear asynchronously, so the output reads 0 until two clean edges have passed.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_p0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_p0 <= 1'b0;
            q       <= 1'b0;
        end else begin
            meta_p0 <= d;
            // second stage: metastability resolved
            q       <= meta_p0;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// Drives the PLL reset, qualifies lock with timeout/retry/stability checks and holds the
// downstream domain in reset until lock is trusted; re-runs the sequence on loss of lock.
module pll_lock_sequencer
    import pll_ctrl_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
    parameter int CNT_W               = DEF_CNT_W
) (
    input  logic                   refclk,
    input  logic                   rst,
    input  logic                   pll_locked,
    input  logic                   restart,
    output logic                   pll_rst,
    output logic                   core_rst,
    output logic                   ready,
    output logic                   fault,
    output logic [RETRY_CNT_W-1:0] retry_cnt,
    output logic [LOL_CNT_W-1:0]   lol_cnt
);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    // The lock_s sample that moves WAIT_LOCK into STABLE is the first stable cycle.
    localparam logic [CNT_W-1:0] STABLE_LAST  =
        CNT_W'((LOCK_STABLE_CYCLES >= 2) ? LOCK_STABLE_CYCLES - 2 : 0);
    localparam logic [RETRY_CNT_W-1:0] RETRY_LIMIT = RETRY_CNT_W'(MAX_RETRIES);
    localparam logic [LOL_CNT_W-1:0]   LOL_MAX     = '1;

    logic                   lock_s;
    pll_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [RETRY_CNT_W-1:0] retry_q, retry_d, retry_inc;
    logic [LOL_CNT_W-1:0]   lol_q, lol_d;
    logic                   pll_rst_d, core_rst_d, ready_d, fault_d;

    sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lock_s)
    );

    assign retry_inc = retry_q + RETRY_CNT_W'(1);
    assign retry_cnt = retry_q;
    assign lol_cnt   = lol_q;

    // State, counters and registered outputs
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q  <= RESET_PLL;
            cnt_q    <= '0;
            retry_q  <= '0;
            lol_q    <= '0;
            pll_rst  <= 1'b1;
            core_rst <= 1'b1;
            ready    <= 1'b0;
            fault    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            retry_q  <= retry_d;
            lol_q    <= lol_d;
            pll_rst  <= pll_rst_d;
            core_rst <= core_rst_d;
            ready    <= ready_d;
            fault    <= fault_d;
        end
    end

    // Next state; the counter restarts from 0 on every transition
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        retry_d = retry_q;
        lol_d   = lol_q;
        if (restart) begin
            state_d = RESET_PLL;
            retry_d = '0;
        end else begin
            case (state_q)
                RESET_PLL: begin
                    if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
                    else                   cnt_d   = cnt_q + CNT_W'(1);
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = STABLE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        retry_d = retry_inc;
                        state_d = (retry_inc == RETRY_LIMIT) ? FAULT : RESET_PLL;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state_d = WAIT_LOCK;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = RUN;
                        retry_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state_d = RESET_PLL;
                        if (lol_q != LOL_MAX) lol_d = lol_q + LOL_CNT_W'(1);
                    end
                end
                FAULT:   state_d = FAULT;
                default: state_d = RESET_PLL;
            endcase
        end
    end

    // Outputs follow the current state one edge later
    always_comb begin
        pll_rst_d  = (state_q == RESET_PLL) || (state_q == FAULT);
        core_rst_d = (state_q != RUN);
        ready_d    = (state_q == RUN);
        fault_d    = (state_q == FAULT);
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with short timing parameters; expected values
// are hand-derived edge counts relative to each stimulus change.
module tb_pll_lock_sequencer;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       restart = 1'b0;
    logic       pll_rst, core_rst, ready, fault;
    logic [1:0] retry_cnt;
    logic [7:0] lol_cnt;

    int total = 0;
    int bad   = 0;

    pll_lock_sequencer #(
        .RST_PULSE_CYCLES    (4),
        .LOCK_TIMEOUT_CYCLES (20),
        .LOCK_STABLE_CYCLES  (8),
        .MAX_RETRIES         (3),
        .CNT_W               (18)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .restart    (restart),
        .pll_rst    (pll_rst),
        .core_rst   (core_rst),
        .ready      (ready),
        .fault      (fault),
        .retry_cnt  (retry_cnt),
        .lol_cnt    (lol_cnt)
    );

    always #5 refclk = ~refclk;

    task automatic step(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int hi;

        // reset state
        step(2);
        chk("rst_pll_rst", 32'(pll_rst), 1);
        chk("rst_core_rst", 32'(core_rst), 1);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_retry", 32'(retry_cnt), 0);
        chk("rst_lol", 32'(lol_cnt), 0);
        rst = 1'b0;

        // nominal lock
        for (int i = 1; i <= 4; i++) begin
            step(1);
            chk("nom_pulse_hi", 32'(pll_rst), 1);
        end
        step(1);
        chk("nom_pulse_lo", 32'(pll_rst), 0);
        chk("nom_core_rst", 32'(core_rst), 1);
        step(9);
        pll_locked = 1'b1;
        step(10);
        chk("nom_ready_early", 32'(ready), 0);
        step(1);
        chk("nom_ready", 32'(ready), 1);
        chk("nom_core_rst_lo", 32'(core_rst), 0);
        chk("nom_retry", 32'(retry_cnt), 0);
        chk("nom_pll_rst", 32'(pll_rst), 0);

        // loss of lock in RUN
        pll_locked = 1'b0;
        step(3);
        chk("lol_ready_3", 32'(ready), 1);
        chk("lol_cnt_1", 32'(lol_cnt), 1);
        step(1);
        chk("lol_ready_4", 32'(ready), 0);
        chk("lol_core_rst", 32'(core_rst), 1);
        chk("lol_pll_rst", 32'(pll_rst), 1);
        pll_locked = 1'b1;
        step(11);
        chk("lol_relock_early", 32'(ready), 0);
        step(1);
        chk("lol_relock", 32'(ready), 1);

        // restart from RUN, then glitchy lock
        restart = 1'b1;
        pll_locked = 1'b0;
        step(1);
        restart = 1'b0;
        chk("rs_lol_kept", 32'(lol_cnt), 1);
        step(1);
        chk("rs_ready", 32'(ready), 0);
        chk("rs_core_rst", 32'(core_rst), 1);
        step(4);
        pll_locked = 1'b1;
        step(5);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(5);
        chk("glitch_ready_delayed", 32'(ready), 0);
        step(5);
        chk("glitch_ready_early", 32'(ready), 0);
        step(1);
        chk("glitch_ready", 32'(ready), 1);
        chk("glitch_retry", 32'(retry_cnt), 0);

        // restart in the same cycle lock_s falls in RUN
        pll_locked = 1'b0;
        step(2);
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        chk("sim_lol_kept", 32'(lol_cnt), 1);
        chk("sim_retry", 32'(retry_cnt), 0);
        step(1);
        chk("sim_ready", 32'(ready), 0);
        chk("sim_pll_rst", 32'(pll_rst), 1);

        // timeouts to fault with lock held low
        for (int k = 1; k <= 3; k++) begin
            step((k == 1) ? 22 : 17);
            chk("to_retry_before", 32'(retry_cnt), 32'(k - 1));
            step(1);
            chk("to_retry_after", 32'(retry_cnt), 32'(k));
            if (k < 3) begin
                hi = 0;
                for (int i = 0; i < 6; i++) begin
                    step(1);
                    hi += int'(pll_rst);
                end
                chk("to_pulse_len", 32'(hi), 4);
            end
        end
        step(1);
        chk("fault_set", 32'(fault), 1);
        chk("fault_pll_rst", 32'(pll_rst), 1);
        chk("fault_core_rst", 32'(core_rst), 1);
        step(10);
        chk("fault_hold", 32'(fault), 1);
        chk("fault_hold_pll_rst", 32'(pll_rst), 1);
        chk("fault_hold_retry", 32'(retry_cnt), 3);

        // restart held for three edges out of FAULT
        restart = 1'b1;
        step(1);
        chk("rf_retry", 32'(retry_cnt), 0);
        step(2);
        chk("rf_fault", 32'(fault), 0);
        chk("rf_pll_rst", 32'(pll_rst), 1);
        restart = 1'b0;
        step(4);
        chk("rf_pulse_end_hi", 32'(pll_rst), 1);
        step(1);
        chk("rf_pulse_end_lo", 32'(pll_rst), 0);
        chk("rf_lol", 32'(lol_cnt), 1);
        pll_locked = 1'b1;
        step(11);
        chk("rf_ready", 32'(ready), 1);
        chk("rf_core_rst", 32'(core_rst), 0);

        // repeated loss of lock until lol_cnt saturates
        for (int i = 1; i <= 300; i++) begin
            pll_locked = 1'b0;
            step(4);
            pll_locked = 1'b1;
            step(12);
            chk("sat_relock", 32'(ready), 1);
            if (i == 253) chk("sat_254", 32'(lol_cnt), 254);
            if (i == 254) chk("sat_255", 32'(lol_cnt), 255);
        end
        chk("sat_final", 32'(lol_cnt), 255);

        // async reset while in STABLE
        pll_locked = 1'b0;
        step(4);
        pll_locked = 1'b1;
        step(6);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_pll_rst", 32'(pll_rst), 1);
        chk("arst_core_rst", 32'(core_rst), 1);
        chk("arst_ready", 32'(ready), 0);
        chk("arst_fault", 32'(fault), 0);
        chk("arst_retry", 32'(retry_cnt), 0);
        chk("arst_lol", 32'(lol_cnt), 0);
        step(2);
        rst = 1'b0;
        step(4);
        chk("arst_pulse_hi", 32'(pll_rst), 1);
        step(1);
        chk("arst_pulse_lo", 32'(pll_rst), 0);
        step(7);
        chk("arst_ready_early", 32'(ready), 0);
        step(1);
        chk("arst_ready", 32'(ready), 1);
        chk("arst_lol_after", 32'(lol_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Sequences the fabric PLL's reset input and qualifies its lock output before releasing the downstream compute clock domain from reset.
- Pulses the PLL reset, waits for lock with a timeout, retries up to a limit, and requires lock to stay stable before declaring ready.
- Detects loss of lock during operation and re-runs the full sequence.
- Sits between the top-level reset and the PLL wrapper; runs on the PLL reference clock.

Parameters:
- RST_PULSE_CYCLES, 16, cycles pll_rst is held high per attempt (>=1).
- LOCK_TIMEOUT_CYCLES, 200000, cycles allowed in WAIT_LOCK before a retry (>=2).
- LOCK_STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before RUN (>=1).
- MAX_RETRIES, 3, failed attempts allowed before FAULT (>=1).
- CNT_W, 18, state-counter width; must hold max(all three cycle parameters).

Ports:
- refclk, input, 1, reference clock; the only clock.
- rst, input, 1, asynchronous active-high reset.
- pll_locked, input, 1, raw PLL locked; asynchronous to refclk.
- restart, input, 1, synchronous single-cycle request to re-run the sequence.
- pll_rst, output, 1, reset to the PLL.
- core_rst, output, 1, active-high reset for the downstream domain.
- ready, output, 1, high only in RUN.
- fault, output, 1, high only in FAULT.
- retry_cnt, output, 2, failed attempts in the current sequence.
- lol_cnt, output, 8, loss-of-lock events since reset; saturates at 255.

Behaviour:
- Clock and reset: one clock, refclk. Reset rst is asynchronous and active-high.
- Outputs: all registered, driven from the state and counters.
- Reset values: state RESET_PLL, counter 0, pll_rst=1, core_rst=1, ready=0, fault=0, retry_cnt=0, lol_cnt=0.
- Lock synchronization: pll_locked passes through a 2-flop synchronizer to give lock_s (2-cycle latency). The synchronizer flops reset to 0.
- Counter: cleared on every state transition.
- RESET_PLL:
  - pll_rst=1, core_rst=1.
  - After RST_PULSE_CYCLES cycles, go to WAIT_LOCK.
- WAIT_LOCK:
  - pll_rst=0.
  - If lock_s=1, go to STABLE.
  - Else, when the counter reaches LOCK_TIMEOUT_CYCLES-1, increment retry_cnt. Go to FAULT if the new value equals MAX_RETRIES, else to RESET_PLL.
  - If lock_s rises in the timeout cycle, lock wins.
- STABLE:
  - lock_s=0 returns to WAIT_LOCK; the counter clears and the timeout restarts; retry_cnt is unchanged.
  - After LOCK_STABLE_CYCLES consecutive cycles with lock_s=1, go to RUN.
- RUN:
  - core_rst=0, ready=1.
  - retry_cnt is cleared on entry.
  - lock_s=0 goes to RESET_PLL and increments lol_cnt (saturating).
  - core_rst=1 and ready=0 appear on the cycle after the transition edge.
- FAULT:
  - pll_rst=1, core_rst=1, fault=1.
  - Exit only via restart.
- restart:
  - From any state, goes to RESET_PLL and clears retry_cnt; lol_cnt is unchanged.
  - Has priority over every other transition in the same cycle, including loss of lock in RUN (lol_cnt is not incremented then).
  - restart held high keeps the block in RESET_PLL with the counter at 0.
- Latency: from raw pll_locked rising and staying high in WAIT_LOCK to ready=1 is 2 + 1 + LOCK_STABLE_CYCLES cycles.
- Reset mid-operation: rst forces the reset values immediately and asynchronously, in any state.

Decomposition:
- Shared package pll_ctrl_pkg holds:
  - the state enum: RESET_PLL, WAIT_LOCK, STABLE, RUN, FAULT;
  - the default cycle constants;
  - the lol_cnt width constant.
- One sub-module: sync_2ff, a 1-bit two-flop synchronizer with asynchronous reset to 0. It is reused elsewhere for other status inputs.
- Everything else (FSM plus counter) lives in pll_lock_sequencer.

Test Plan:
Bench parameters: RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=3.
- Nominal lock: rst released, pll_locked raised 10 cycles after pll_rst falls -> pll_rst high exactly 4 cycles; ready=1 and core_rst=0 exactly 11 cycles after pll_locked rises; retry_cnt=0.
- Glitchy lock: pll_locked high 5 cycles, low 1 cycle, then high -> STABLE aborts to WAIT_LOCK; ready is delayed by the restart of the 8-cycle window; no retry counted.
- Timeouts to fault: pll_locked held 0 -> three pll_rst pulses, retry_cnt steps 1, 2, 3; fault=1 after the 3rd timeout; pll_rst stays 1; restart pulse -> fault=0, retry_cnt=0, new 4-cycle pll_rst pulse.
- Loss of lock: in RUN, drop pll_locked -> ready=0 and core_rst=1 on the 4th refclk edge after the drop; lol_cnt=1; the sequence re-runs and relocks when pll_locked returns.
- Simultaneous events: restart asserted in the same cycle lock_s falls in RUN -> RESET_PLL and lol_cnt unchanged.
  - 300 loss-of-lock cycles -> lol_cnt saturates at 255.
- Async reset mid-STABLE: assert rst between clock edges -> all outputs take reset values before the next refclk edge; the sequence restarts cleanly after release.
